// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random source: tap masks, FSM states and
// the bounded-draw mask helper.
package lfsr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic bit width_legal(input int width);
      return (width == 8) || (width == 16) || (width == 24) || (width == 32);
   endfunction

   // Bit i set means q[i] feeds the XOR, i.e. exponent i+1 of the polynomial.
   function automatic logic [31:0] tap_mask(input int width);
      logic [31:0] taps;
      case (width)
         8:       taps = 32'h0000_00B8;
         16:      taps = 32'h0000_D008;
         24:      taps = 32'h00E1_0000;
         32:      taps = 32'h8020_0003;
         default: taps = 32'h0000_0000;
      endcase
      return taps;
   endfunction

   // Smallest 2^k-1 covering bound-1; bound 0 means the full range.
   function automatic logic [31:0] range_mask(input logic [31:0] bound);
      logic [31:0] m;
      if (bound == 32'd0) begin
         m = 32'hFFFF_FFFF;
      end else begin
         m = bound - 32'd1;
         for (int i = 0; i < 5; i++) begin
            m = m | (m >> (32'd1 << i));
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// Request/response port of the shared random source.
interface lfsr_rng_if #(
   parameter int OUT_W = 8
);
   logic             req_valid;
   logic [OUT_W-1:0] req_bound;
   logic             req_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [OUT_W-1:0] rsp_data;
   logic             rsp_fallback;

   modport master (
      output req_valid, req_bound, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_fallback
   );

   modport slave (
      input  req_valid, req_bound, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_fallback
   );
endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with run-time seed load and step enable.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] TAPS =
      width_legal(WIDTH) ? WIDTH'(tap_mask(WIDTH)) : {WIDTH{1'b0}};

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_s;
   logic             fb_s;

   // Next state: load beats step; a zero seed would freeze the register, so it becomes all ones.
   always_comb begin
      q_s  = q_r;
      fb_s = ^(q_r & TAPS);
      if (load) begin
         if (seed == {WIDTH{1'b0}}) begin
            q_s = {WIDTH{1'b1}};
         end else begin
            q_s = seed;
         end
      end else if (step) begin
         q_s = {q_r[WIDTH-2:0], fb_s};
      end else begin
         q_s = q_r;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r <= {WIDTH{1'b1}};
      end else begin
         q_r <= q_s;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/lfsr_rng.sv
// Shared random source: free-running LFSR plus bounded draws by masked
// rejection sampling with a halved-candidate fallback after MAX_TRIES.
module lfsr_rng
   import lfsr_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int OUT_W     = 8,
   parameter int MAX_TRIES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] q,
   lfsr_rng_if.slave        bus
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   state_t           state_r;
   state_t           state_s;
   logic [OUT_W-1:0] bound_r;
   logic [OUT_W-1:0] bound_s;
   logic [OUT_W-1:0] mask_r;
   logic [OUT_W-1:0] mask_s;
   logic [TRY_W-1:0] tries_r;
   logic [TRY_W-1:0] tries_s;
   logic [OUT_W-1:0] data_r;
   logic [OUT_W-1:0] data_s;
   logic             fb_r;
   logic             fb_s;
   logic             valid_r;
   logic             ready_r;
   logic [WIDTH-1:0] q_s;
   logic [OUT_W-1:0] cand_s;
   logic             accept_s;
   logic             step_s;

   // The draw consumes one LFSR step per attempt, whatever en says.
   assign step_s = en | (state_r == ST_DRAW);

   lfsr_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk  (clk),
      .rst  (rst),
      .step (step_s),
      .load (seed_load),
      .seed (seed),
      .q    (q_s)
   );

   assign q        = q_s;
   assign cand_s   = q_s[OUT_W-1:0] & mask_r;
   assign accept_s = (bound_r == {OUT_W{1'b0}}) || (cand_s < bound_r);

   // Next-state and draw datapath.
   always_comb begin
      state_s = state_r;
      bound_s = bound_r;
      mask_s  = mask_r;
      tries_s = tries_r;
      data_s  = data_r;
      fb_s    = fb_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.req_valid && ready_r) begin
               bound_s = bus.req_bound;
               mask_s  = OUT_W'(range_mask(32'(bus.req_bound)));
               tries_s = {TRY_W{1'b0}};
               state_s = ST_DRAW;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_DRAW: begin
            if (accept_s) begin
               data_s  = cand_s;
               fb_s    = 1'b0;
               state_s = ST_RESP;
            end else if ((tries_r + TRY_W'(1)) == TRY_W'(MAX_TRIES)) begin
               // cand < 2*bound always, so half of it is in range for bound >= 2.
               data_s  = cand_s >> 1'b1;
               fb_s    = 1'b1;
               state_s = ST_RESP;
            end else begin
               tries_s = tries_r + TRY_W'(1);
               state_s = ST_DRAW;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM, draw context and registered response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         bound_r <= {OUT_W{1'b0}};
         mask_r  <= {OUT_W{1'b0}};
         tries_r <= {TRY_W{1'b0}};
         data_r  <= {OUT_W{1'b0}};
         fb_r    <= 1'b0;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_s;
         bound_r <= bound_s;
         mask_r  <= mask_s;
         tries_r <= tries_s;
         data_r  <= data_s;
         fb_r    <= fb_s;
         valid_r <= (state_s == ST_RESP);
         ready_r <= (state_s == ST_IDLE);
      end
   end

   assign bus.req_ready    = ready_r;
   assign bus.rsp_valid    = valid_r;
   assign bus.rsp_data     = data_r;
   assign bus.rsp_fallback = fb_r;

endmodule

// File: tb/tb_lfsr_rng.sv
// Bench for lfsr_rng: cycle-level checks against a draw-lookahead model,
// directed boundary cases and a second instance with MAX_TRIES=1.
module tb_lfsr_rng;

   localparam int MAXT = 8;
   localparam int EXPS [4] = '{16, 15, 13, 4};

   logic        clk = 1'b0;
   logic        rst1, rst2;
   logic        en1, sl1, en2, sl2;
   logic [15:0] seed1, seed2, q1, q2;

   lfsr_rng_if #(.OUT_W(8)) bus1 ();
   lfsr_rng_if #(.OUT_W(8)) bus2 ();

   lfsr_rng #(.WIDTH(16), .OUT_W(8), .MAX_TRIES(MAXT)) u_dut (
      .clk(clk), .rst(rst1), .en(en1), .seed_load(sl1), .seed(seed1), .q(q1), .bus(bus1)
   );

   lfsr_rng #(.WIDTH(16), .OUT_W(8), .MAX_TRIES(1)) u_dut1t (
      .clk(clk), .rst(rst2), .en(en2), .seed_load(sl2), .seed(seed2), .q(q2), .bus(bus2)
   );

   always #5 clk = ~clk;

   int test_cnt = 0;
   int fail_cnt = 0;

   // model state
   logic [15:0] mq;
   bit          pend;
   int          wait_cnt;
   logic [7:0]  exp_data;
   bit          exp_fb;
   int          cyc, hs_cyc, n_rsp, last_lat;
   logic [7:0]  last_data;
   bit          last_fb;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      test_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      logic fb = 1'b0;
      foreach (EXPS[i]) fb ^= v[EXPS[i]-1];
      return {v[14:0], fb};
   endfunction

   // Look ahead over the draw cycles starting from state q0 and fix the outcome.
   task automatic predict(input logic [15:0] q0, input logic [7:0] bound);
      int mask, cand;
      bit done;
      logic [15:0] qq;
      qq = q0;
      mask = 0;
      done = 1'b0;
      if (bound == 8'd0) mask = 255;
      else while (mask < int'(bound) - 1) mask = mask * 2 + 1;
      for (int t = 0; t < MAXT && !done; t++) begin
         cand = int'(qq[7:0]) & mask;
         if (bound == 8'd0 || cand < int'(bound)) begin
            exp_data = 8'(cand); exp_fb = 1'b0; wait_cnt = t + 1; done = 1'b1;
         end else if (t == MAXT - 1) begin
            exp_data = 8'(cand / 2); exp_fb = 1'b1; wait_cnt = MAXT; done = 1'b1;
         end
         qq = lfsr_next(qq);
      end
   endtask

   // One clock of dut 1: compare against the model, advance the model, cross the edge.
   task automatic tick();
      bit drawing, vexp;
      logic [15:0] qn;
      drawing = pend && (wait_cnt > 0);
      vexp    = pend && (wait_cnt == 0);
      check_val("q", q1, mq);
      check_val("req_ready", bus1.req_ready, !pend);
      check_val("rsp_valid", bus1.rsp_valid, vexp);
      if (vexp) begin
         check_val("rsp_data", bus1.rsp_data, exp_data);
         check_val("rsp_fallback", bus1.rsp_fallback, exp_fb);
      end
      if (sl1) qn = (seed1 == 16'h0000) ? 16'hFFFF : seed1;
      else if (en1 || drawing) qn = lfsr_next(mq);
      else qn = mq;
      if (vexp && bus1.rsp_ready) begin
         pend = 1'b0; last_data = exp_data; last_fb = exp_fb;
         last_lat = cyc - hs_cyc; n_rsp++;
      end else if (drawing) begin
         wait_cnt--;
      end else if (!pend && bus1.req_valid) begin
         predict(qn, bus1.req_bound);
         pend = 1'b1; hs_cyc = cyc;
      end
      mq = qn;
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_req(input logic [7:0] bound);
      int n0, budget;
      n0 = n_rsp;
      budget = 0;
      bus1.req_valid = 1'b1;
      bus1.req_bound = bound;
      tick();
      bus1.req_valid = 1'b0;
      while (n_rsp == n0 && budget < 40) begin
         tick();
         budget++;
      end
      check_val("rsp_done", n_rsp - n0, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", test_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] seq [6];
      logic [7:0]  dq, hd;
      int zero_seen, first_ret, n0, b;
      logic [7:0] bset [10];
      seq  = '{16'hFFFF, 16'hFFFE, 16'hFFFC, 16'hFFF8, 16'hFFF0, 16'hFFE1};
      bset = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd9, 8'd17, 8'd65, 8'd129, 8'd200};

      rst1 = 1'b1; rst2 = 1'b1;
      en1 = 1'b0; sl1 = 1'b0; seed1 = 16'h0000;
      en2 = 1'b0; sl2 = 1'b0; seed2 = 16'h0000;
      bus1.req_valid = 1'b0; bus1.req_bound = 8'd0; bus1.rsp_ready = 1'b0;
      bus2.req_valid = 1'b0; bus2.req_bound = 8'd0; bus2.rsp_ready = 1'b0;
      mq = 16'hFFFF; pend = 1'b0; wait_cnt = 0; cyc = 0; hs_cyc = 0; n_rsp = 0;
      last_lat = 0; last_data = 8'd0; last_fb = 1'b0;

      #1;
      check_val("rst_q", q1, 16'hFFFF);
      check_val("rst_rsp_valid", bus1.rsp_valid, 1'b0);
      check_val("rst_rsp_data", bus1.rsp_data, 8'd0);
      check_val("rst_rsp_fallback", bus1.rsp_fallback, 1'b0);
      @(negedge clk);
      rst1 = 1'b0; rst2 = 1'b0;
      check_val("rst_req_ready", bus1.req_ready, 1'b1);

      // free-run sequence out of reset
      en1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check_val("seq", q1, seq[i]);
         tick();
      end

      // zero seed, then a full period
      en1 = 1'b0; sl1 = 1'b1; seed1 = 16'h0000;
      tick();
      sl1 = 1'b0;
      check_val("seed_zero", q1, 16'hFFFF);
      en1 = 1'b1; zero_seen = 0; first_ret = -1;
      for (int i = 1; i <= 65535; i++) begin
         tick();
         if (q1 == 16'h0000) zero_seen++;
         if (q1 == 16'hFFFF && first_ret < 0) first_ret = i;
      end
      check_val("period", first_ret, 65535);
      check_val("zero_state", zero_seen, 0);

      en1 = 1'b0; sl1 = 1'b1; seed1 = 16'h1234;
      tick();
      sl1 = 1'b0;
      check_val("seed_1234", q1, 16'h1234);

      // bound 1 and bound 0
      bus1.rsp_ready = 1'b1;
      run_req(8'd1);
      check_val("b1_data", last_data, 8'd0);
      check_val("b1_fallback", last_fb, 1'b0);
      bus1.req_valid = 1'b1; bus1.req_bound = 8'd0;
      tick();
      bus1.req_valid = 1'b0;
      dq = q1[7:0];
      n0 = n_rsp; b = 0;
      while (n_rsp == n0 && b < 40) begin tick(); b++; end
      check_val("b0_data", last_data, dq);
      check_val("b0_latency", last_lat, 2);

      // 1000 draws with bound 10
      for (int i = 0; i < 1000; i++) begin
         en1 = 1'($urandom_range(0, 1));
         run_req(8'd10);
         check_val("b10_range", last_data < 8'd10, 1'b1);
      end

      // back-pressure: response must hold while q keeps moving
      en1 = 1'b1; bus1.rsp_ready = 1'b0;
      bus1.req_valid = 1'b1; bus1.req_bound = 8'd10;
      tick();
      bus1.req_valid = 1'b0;
      b = 0;
      while (!(pend && wait_cnt == 0) && b < 40) begin tick(); b++; end
      check_val("hold_valid", bus1.rsp_valid, 1'b1);
      hd = bus1.rsp_data;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("hold_data", bus1.rsp_data, hd);
         check_val("hold_ready", bus1.req_ready, 1'b0);
      end
      n0 = n_rsp;
      bus1.rsp_ready = 1'b1;
      tick();
      check_val("hold_release", n_rsp - n0, 1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         en1 = ($urandom_range(0, 3) != 0);
         sl1 = 1'b0;
         if (!(pend && wait_cnt > 1) && $urandom_range(0, 15) == 0) begin
            sl1 = 1'b1;
            seed1 = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         end
         bus1.req_valid = ($urandom_range(0, 2) == 0);
         bus1.req_bound = ($urandom_range(0, 1) == 0) ? bset[$urandom_range(0, 9)]
                                                       : 8'($urandom);
         bus1.rsp_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      en1 = 1'b0; sl1 = 1'b0; bus1.req_valid = 1'b0;

      // MAX_TRIES=1: cand 7 against bound 5 forces the fallback 7>>1
      sl2 = 1'b1; seed2 = 16'h0007;
      bus2.req_valid = 1'b1; bus2.req_bound = 8'd5; bus2.rsp_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      sl2 = 1'b0; bus2.req_valid = 1'b0;
      check_val("t1_seed", q2, 16'h0007);
      check_val("t1_draw_valid", bus2.rsp_valid, 1'b0);
      @(posedge clk); @(negedge clk);
      check_val("t1_valid", bus2.rsp_valid, 1'b1);
      check_val("t1_data", bus2.rsp_data, 8'd3);
      check_val("t1_fallback", bus2.rsp_fallback, 1'b1);
      bus2.rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus2.rsp_ready = 1'b0;
      check_val("t1_idle", bus2.req_ready, 1'b1);

      // reset while drawing discards the result
      sl2 = 1'b1; seed2 = 16'h0003;
      bus2.req_valid = 1'b1; bus2.req_bound = 8'd5;
      @(posedge clk); @(negedge clk);
      sl2 = 1'b0; bus2.req_valid = 1'b0;
      check_val("rd_draw_ready", bus2.req_ready, 1'b0);
      rst2 = 1'b1;
      #1;
      check_val("rd_q", q2, 16'hFFFF);
      check_val("rd_valid", bus2.rsp_valid, 1'b0);
      @(negedge clk);
      rst2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         check_val("rd_after_valid", bus2.rsp_valid, 1'b0);
         check_val("rd_after_q", q2, 16'hFFFF);
      end

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised Fibonacci-LFSR random source with a request/response port for bounded draws. Exposes the raw free-running state for cheap randomness (game effects, spawn positions), supports run-time reseeding, and serves range-limited values in [0, bound-1] by masked rejection sampling with a guaranteed-bounded fallback. Sits beside the game controller as the single shared random source.

## Interface
- WIDTH, 16, LFSR width; legal values 8, 16, 24, 32 only
- OUT_W, 8, width of bounded draw results; 1 ≤ OUT_W ≤ WIDTH
- MAX_TRIES, 8, rejection attempts before fallback; ≥ 1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  free-run step enable
- seed_load  in  1  load seed this cycle
- seed  in  WIDTH  seed value
- q  out  WIDTH  current LFSR state
- req_valid  in  1  bounded-draw request
- req_bound  in  OUT_W  exclusive upper bound
- req_ready  out  1  high in IDLE only
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  OUT_W  result
- rsp_fallback  out  1  result came from fallback path

## Operation
- Polynomials: 8: x^8+x^6+x^5+x^4+1; 16: x^16+x^15+x^13+x^4+1; 24: x^24+x^23+x^22+x^17+1; 32: x^32+x^22+x^2+x^1+1.
- Step: shift left; new q[0] = XOR of q[n-1] over every nonzero exponent n (WIDTH=16: q[3]^q[12]^q[14]^q[15]).
- Reset: q = all ones; state IDLE; rsp_valid 0, rsp_data 0, rsp_fallback 0; req_ready 1 once out of reset.
- Priority each cycle: seed_load > step > hold. seed == 0 loads all ones (no lock-up). Step occurs when en=1 or state=DRAW.
- FSM: IDLE, DRAW, RESP.
  - IDLE: req_valid & req_ready latches bound, clears try counter → DRAW.
  - DRAW: mask = smallest 2^k−1 ≥ bound−1; cand = q[OUT_W-1:0] & mask. bound=0: mask all ones, always accept. bound=1: cand=0, accept. cand < bound → rsp_data=cand, fallback=0 → RESP. Else tries+1; if tries reaches MAX_TRIES → rsp_data=cand>>1, fallback=1 → RESP; else stay.
  - RESP: rsp_valid=1; rsp_data/rsp_fallback stable until rsp_valid & rsp_ready → IDLE.
- seed_load never aborts the FSM; a DRAW cycle coinciding with seed_load evaluates the pre-load q.
- Fallback cand>>1 < bound holds for all bound ≥ 2.

## Timing
- q updates one cycle after step/seed_load condition.
- Request handshake cycle N; first-try accept gives rsp_valid at N+2; each rejection adds one cycle; worst case N+1+MAX_TRIES.
- rsp_valid registered; rsp_ready combinationally affects only next-state.
- rst mid-draw: FSM to IDLE, pending result discarded, q to all ones immediately.

## Structure
- Package lfsr_pkg: tap-mask function/constants per WIDTH, FSM state enum, legal-WIDTH check.
- Sub-module lfsr_core (WIDTH): shift register, seed load, zero-seed substitution, step enable; top holds FSM, mask computation, try counter.

## Test plan
- Reset, WIDTH=16, en=1 → q sequence FFFF, FFFE, FFFC, FFF8, FFF0, FFE1.
- Free-run 65535 steps from FFFF → returns to FFFF, never 0000 in between.
- seed_load with seed=0 → q=FFFF next cycle; seed=1234 → q=1234.
- req_bound=1 → rsp_data=0, fallback=0; req_bound=0 → rsp_data = q[7:0] at DRAW cycle, latency 2.
- 1000 draws req_bound=10 → all rsp_data < 10; hold rsp_ready=0 for 5 cycles → rsp_data stable, req_ready=0.
- MAX_TRIES=1, bound=5, seed chosen so cand=7 → rsp_data=3, rsp_fallback=1; rst asserted in DRAW → rsp_valid stays 0, q=FFFF.
